// File: rtl/piano_voice.sv
// Single-voice square-wave tone generator with fixed-priority key select and release sustain.
// Optional octave shift: define PIANO_OCTAVE_EN to add the octave_up port.
module piano_voice #(
    parameter int NUM_KEYS    = 8,
    parameter int DIV_W       = 18,
    parameter int DEFAULT_DIV = 95556,
    parameter int SUSTAIN_CYC = 10000000,
    parameter int NOTE_W      = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                cfg_we,
    input  logic [NOTE_W-1:0]   cfg_addr,
    input  logic [DIV_W-1:0]    cfg_data,
`ifdef PIANO_OCTAVE_EN
    input  logic                octave_up,
`endif
    output logic                tone,
    output logic [NOTE_W-1:0]   note,
    output logic                note_valid,
    output logic [NUM_KEYS-1:0] Led
);

    // state   | meaning
    // IDLE    | silent, no note held
    // PLAY    | a key is down, tone running for note
    // SUSTAIN | all keys released, tone runs until sus_cnt expires
    typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;

    localparam int SUS_W = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
    localparam logic [SUS_W-1:0] SUS_LOAD = (SUSTAIN_CYC > 0) ? SUS_W'(SUSTAIN_CYC - 1) : '0;

    state_t               state;
    logic [DIV_W-1:0]     cnt;
    logic [SUS_W-1:0]     sus_cnt;
    logic [DIV_W-1:0]     div_tab [NUM_KEYS];

    logic                 key_any;
    logic [NOTE_W-1:0]    pri_note;
    logic [NUM_KEYS-1:0]  pri_onehot;
    logic [DIV_W-1:0]     raw_pri, raw_cur, eff_pri, eff_cur;
    logic                 start_tone, run_tone;
    logic [DIV_W-1:0]     start_cnt, run_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_KEYS; i++) div_tab[i] <= DIV_W'(DEFAULT_DIV);
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_KEYS; i++)
                if (cfg_addr == NOTE_W'(i)) div_tab[i] <= cfg_data;
        end
    end

    always_comb begin
        pri_note = '0;
        raw_pri  = '0;
        raw_cur  = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (key[i]) pri_note = NOTE_W'(i);
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pri_note == NOTE_W'(i)) raw_pri = div_tab[i];
            if (note == NOTE_W'(i))     raw_cur = div_tab[i];
        end
    end

    assign key_any    = |key;
    assign pri_onehot = key & (~key + NUM_KEYS'(1));

`ifdef PIANO_OCTAVE_EN
    assign eff_pri = octave_up ? (raw_pri >> 1) : raw_pri;
    assign eff_cur = octave_up ? (raw_cur >> 1) : raw_cur;
`else
    assign eff_pri = raw_pri;
    assign eff_cur = raw_cur;
`endif

    // A zero divisor mutes: the counter reloads every cycle so a later table write is picked up.
    assign start_tone = (eff_pri != '0);
    assign start_cnt  = (eff_pri == '0) ? '0 : eff_pri - DIV_W'(1);
    assign run_tone   = (cnt == '0) ? ((eff_cur != '0) && !tone) : tone;
    assign run_cnt    = (cnt != '0) ? cnt - DIV_W'(1) :
                        (eff_cur == '0) ? '0 : eff_cur - DIV_W'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            tone       <= 1'b0;
            note       <= '0;
            note_valid <= 1'b0;
            Led        <= '0;
            cnt        <= '0;
            sus_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_any) begin
                        state      <= PLAY;
                        note       <= pri_note;
                        note_valid <= 1'b1;
                        Led        <= pri_onehot;
                        tone       <= start_tone;
                        cnt        <= start_cnt;
                    end
                end
                PLAY: begin
                    if (key_any) begin
                        if (pri_note != note) begin
                            note <= pri_note;
                            Led  <= pri_onehot;
                            tone <= start_tone;
                            cnt  <= start_cnt;
                        end else begin
                            tone <= run_tone;
                            cnt  <= run_cnt;
                        end
                    end else if (SUSTAIN_CYC == 0) begin
                        state      <= IDLE;
                        tone       <= 1'b0;
                        note_valid <= 1'b0;
                        Led        <= '0;
                        cnt        <= '0;
                    end else begin
                        state   <= SUSTAIN;
                        sus_cnt <= SUS_LOAD;
                        tone    <= run_tone;
                        cnt     <= run_cnt;
                    end
                end
                SUSTAIN: begin
                    if (key_any) begin
                        state <= PLAY;
                        if (pri_note != note) begin
                            note <= pri_note;
                            Led  <= pri_onehot;
                            tone <= start_tone;
                            cnt  <= start_cnt;
                        end else begin
                            tone <= run_tone;
                            cnt  <= run_cnt;
                        end
                    end else if (sus_cnt == '0) begin
                        state      <= IDLE;
                        tone       <= 1'b0;
                        note_valid <= 1'b0;
                        Led        <= '0;
                        cnt        <= '0;
                    end else begin
                        sus_cnt <= sus_cnt - SUS_W'(1);
                        tone    <= run_tone;
                        cnt     <= run_cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piano_voice.sv
// Bench for piano_voice: directed steps plus random keys/cfg writes against a timestamp-based model.
module tb_piano_voice;
    localparam int NK = 8;
    localparam int DW = 18;
    localparam int NW = 4;
    localparam int DD = 4;
    localparam int S  = 10;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [NK-1:0] key = '0;
    logic          cfg_we = 1'b0;
    logic [NW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          octave_up = 1'b0;
    logic          tone;
    logic [NW-1:0] note;
    logic          note_valid;
    logic [NK-1:0] Led;

    int checks = 0;
    int errors = 0;

    piano_voice #(.NUM_KEYS(NK), .DIV_W(DW), .DEFAULT_DIV(DD), .SUSTAIN_CYC(S), .NOTE_W(NW)) dut (
        .CLK(CLK), .RESET(RESET), .key(key), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
`ifdef PIANO_OCTAVE_EN
        .octave_up(octave_up),
`endif
        .tone(tone), .note(note), .note_valid(note_valid), .Led(Led));

    always #5 CLK = ~CLK;

    // Reference: level age vs. half-period latched at start/reload, release timestamp for sustain.
    logic [DW-1:0] mtab [NK];
    bit  m_valid, m_tone;
    int  m_note, m_len, m_age, m_rel, t;

    function automatic int eff_of(input int p);
        int v;
        v = int'(mtab[p]);
`ifdef PIANO_OCTAVE_EN
        if (octave_up) v = v / 2;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NK; i++) mtab[i] = DW'(DD);
        m_valid = 0; m_tone = 0; m_note = 0; m_len = 0; m_age = 0; m_rel = -1; t = 0;
    endtask

    task automatic m_start(input int p);
        m_note = p; m_valid = 1; m_len = eff_of(p); m_age = 0; m_tone = (m_len != 0);
    endtask

    task automatic m_advance();
        m_age++;
        if (m_age >= ((m_len == 0) ? 1 : m_len)) begin
            m_len = eff_of(m_note);
            m_age = 0;
            m_tone = (m_len != 0) ? !m_tone : 1'b0;
        end
    endtask

    task automatic model_step();
        int pri;
        pri = -1;
        for (int i = NK - 1; i >= 0; i--) if (key[i]) pri = i;
        if (!m_valid) begin
            if (pri >= 0) m_start(pri);
        end else if (pri >= 0) begin
            m_rel = -1;
            if (pri != m_note) m_start(pri); else m_advance();
        end else begin
            if (m_rel < 0) m_rel = t;
            if (t - m_rel == S) begin
                m_valid = 0; m_tone = 0; m_rel = -1;
            end else m_advance();
        end
        if (cfg_we && int'(cfg_addr) < NK) mtab[int'(cfg_addr)] = cfg_data;
        t++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic compare_all();
        check("tone", 32'(tone), 32'(m_tone));
        check("note_valid", 32'(note_valid), 32'(m_valid));
        check("led", 32'(Led), m_valid ? (32'(1) << m_note) : 32'(0));
        if (m_valid) check("note", 32'(note), 32'(m_note));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            model_step();
            @(posedge CLK);
            #1;
            compare_all();
        end
    endtask

    task automatic write(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = NW'(a); cfg_data = DW'(d);
        tick(1);
        cfg_we = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_tone", 32'(tone), 32'(0));
        check("rst_valid", 32'(note_valid), 32'(0));
        check("rst_led", 32'(Led), 32'(0));
        check("rst_note", 32'(note), 32'(0));
        RESET = 1'b0;

        key = 8'b0000_0100; tick(1);
        check("first_note", 32'(note), 32'(2));
        check("first_tone", 32'(tone), 32'(1));
        tick(14);

        // asynchronous reset mid-tone
        RESET = 1'b1; #1;
        check("async_tone", 32'(tone), 32'(0));
        check("async_valid", 32'(note_valid), 32'(0));
        check("async_led", 32'(Led), 32'(0));
        check("async_note", 32'(note), 32'(0));
        model_reset();
        key = '0;
        #2 RESET = 1'b0;

        key = 8'b1000_0100; tick(10);
        key = 8'b1000_0000; tick(10);
        key = 8'b1000_0100; tick(10);
        key = '0; tick(15);

        key = 8'b0000_0100; tick(3);
        key = '0; tick(5);
        key = 8'b0000_0100; tick(6);
        key = '0; tick(15);

        write(3, 6);
        key = 8'b0000_1000; tick(20);
        write(3, 0); tick(10);
        write(9, 1); tick(5);
        key = '0; tick(15);
        key = 8'b0000_1000; tick(5);
        key = '0; tick(12);
        write(3, 5);

`ifdef PIANO_OCTAVE_EN
        write(1, 8);
        key = 8'b0000_0010; octave_up = 1'b1; tick(12);
        octave_up = 1'b0; tick(20);
        key = '0; tick(12);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                key = ($urandom_range(0, 2) == 0) ? '0 : NK'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1'b1;
                cfg_addr = NW'($urandom_range(0, 9));
                cfg_data = DW'($urandom_range(0, 7));
            end else cfg_we = 1'b0;
`ifdef PIANO_OCTAVE_EN
            if ($urandom_range(0, 9) == 0) octave_up = ~octave_up;
`endif
            tick(1);
        end
        cfg_we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
